// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
//   - arb_state_e : FSM state encoding (fixed 3-bit values)
//   - OWNER_IF/OWNER_D : owner bit values, also the bit index of each
//     requester in the 2-bit request/grant vectors
//   - DEF_ADDR_WIDTH/DEF_DATA_WIDTH : default parameter values
//   - rr_pick : 2-way round-robin grant selection
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 8;

    // One-hot grant for requests {data, fetch}. On a tie the port that
    // was not granted last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] g;
        g = 2'b00;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == OWNER_D) ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : requests, bit 0 = fetch, bit 1 = data
//   advance      : when high and any request is present, the grant is
//                  taken and the last-grant pointer moves to the winner
//   grant[1:0]   : one-hot grant (combinational, valid every cycle)
// The pointer resets to fetch so the data port wins the first tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;
    logic [1:0] grant_s;

    // Grant selection and pointer update
    always_comb begin
        grant_s      = rr_pick(req, last_grant_q);
        last_grant_d = last_grant_q;
        if (advance && (grant_s != 2'b00)) begin
            last_grant_d = grant_s[1] ? OWNER_D : OWNER_IF;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant pointer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= OWNER_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a single-port memory between a read-only fetch
// port and a load/store data port, and sequences the memory's two-phase
// write (cycle A: write-request + data on bus[7:0]; cycle B: address).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   if_req/if_addr               : fetch request (held until if_ack)
//   if_ack/if_rdata              : one-cycle ack, fetched byte (held after)
//   d_req/d_we/d_addr/d_wdata    : data request (held until d_ack)
//   d_ack/d_rdata                : one-cycle ack, loaded byte (held after)
//   mem_write_req/mem_req_bus    : to memory
//   mem_read_data                : combinational read data from memory
//   busy                         : high whenever the FSM is not idle
// All outputs are flops loaded from the next-state value, so each output
// lines up with the state it belongs to while staying glitch-free.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_write_req,
    output logic [ADDR_WIDTH-1:0] mem_req_bus,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy
);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic                  mem_write_req_q, mem_write_req_d;
    logic [ADDR_WIDTH-1:0] mem_req_bus_q, mem_req_bus_d;
    logic                  busy_q, busy_d;

    logic [1:0] grant_s;
    logic       advance_s;

    assign advance_s = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({d_req, if_req}),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s[1]) begin
                    owner_d = OWNER_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = d_we ? ST_WR_DATA : ST_RD;
                end else if (grant_s[0]) begin
                    // Fetch is read-only: we is forced low.
                    owner_d = OWNER_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (owner_q == OWNER_D) begin
                    d_rdata_d = mem_read_data;
                end else begin
                    if_rdata_d = mem_read_data;
                end
                state_d = ST_RESP;
            end
            ST_WR_DATA: state_d = ST_WR_ADDR;
            ST_WR_ADDR: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        mem_write_req_d = 1'b0;
        mem_req_bus_d   = '0;
        if_ack_d        = 1'b0;
        d_ack_d         = 1'b0;
        busy_d          = (state_d != ST_IDLE);
        case (state_d)
            ST_RD:      mem_req_bus_d = addr_d;
            ST_WR_DATA: begin
                mem_write_req_d = 1'b1;
                mem_req_bus_d   = ADDR_WIDTH'(wdata_d);
            end
            ST_WR_ADDR: mem_req_bus_d = addr_d;
            ST_RESP: begin
                if (owner_d == OWNER_D) begin
                    d_ack_d = 1'b1;
                end else begin
                    if_ack_d = 1'b1;
                end
            end
            default: begin
                mem_write_req_d = 1'b0;
                mem_req_bus_d   = '0;
            end
        endcase
    end

    // State, request latches, read data and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWNER_IF;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            if_rdata_q      <= '0;
            d_rdata_q       <= '0;
            if_ack_q        <= 1'b0;
            d_ack_q         <= 1'b0;
            mem_write_req_q <= 1'b0;
            mem_req_bus_q   <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            if_rdata_q      <= if_rdata_d;
            d_rdata_q       <= d_rdata_d;
            if_ack_q        <= if_ack_d;
            d_ack_q         <= d_ack_d;
            mem_write_req_q <= mem_write_req_d;
            mem_req_bus_q   <= mem_req_bus_d;
            busy_q          <= busy_d;
        end
    end

    assign if_ack        = if_ack_q;
    assign if_rdata      = if_rdata_q;
    assign d_ack         = d_ack_q;
    assign d_rdata       = d_rdata_q;
    assign mem_write_req = mem_write_req_q;
    assign mem_req_bus   = mem_req_bus_q;
    assign busy          = busy_q;

    // we_q is kept for debug visibility of the latched request.
    logic unused_s;
    assign unused_s = we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes the
// expected ack (port and read byte) into a queue; a negedge monitor pops
// and compares each ack the DUT produces.
module tb_mem_bus_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_write_req;
    logic [AW-1:0] mem_req_bus;
    logic [DW-1:0] mem_read_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         port;   // 0 = fetch, 1 = data
        bit         chk;    // compare read data
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_wr = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_write_req(mem_write_req), .mem_req_bus(mem_req_bus),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    // Memory model: two-phase write, combinational read, 256 bytes.
    logic [7:0] mem [0:255];
    logic [7:0] wlat;
    logic       pend;
    logic       init_done = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
            if (!init_done) begin
                for (int i = 0; i < 256; i++)
                    mem[i] <= (i == 4) ? 8'h01 : (8'(i) ^ 8'h3C);
                init_done <= 1'b1;
            end
        end else if (mem_write_req) begin
            wlat <= mem_req_bus[7:0];
            pend <= 1'b1;
        end else if (pend) begin
            mem[mem_req_bus[7:0]] <= wlat;
            pend <= 1'b0;
        end
    end
    assign mem_read_data = mem[mem_req_bus[7:0]];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit port, input bit chk, input logic [7:0] data);
        exp_t e;
        e.port = port; e.chk = chk; e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the port's ack; n = negedges waited.
    task automatic wait_ack(input bit port, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((port ? d_ack : if_ack) !== 1'b1) && n < 30);
        check(nm, 32'(n < 30), 32'd1);
    endtask

    // Monitor: scoreboard pop on ack, plus protocol invariants
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr = 1'b0;
        end else begin
            if (mem_write_req && prev_wr) check("wr_req_twice", 32'd1, 32'd0);
            if (if_ack || d_ack) begin
                if (if_ack && d_ack) begin
                    check("ack_overlap", 32'd1, 32'd0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_ack", {31'd0, d_ack}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port});
                    if (mon_e.chk)
                        check("ack_rdata", {24'd0, (d_ack ? d_rdata : if_rdata)}, {24'd0, mon_e.data});
                end
            end
            prev_wr = mem_write_req;
        end
    end

    task automatic check_quiet(input string nm);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_wr"},   {31'd0, mem_write_req}, 32'd0);
        check({nm, "_bus"},  {17'd0, mem_req_bus}, 32'd0);
        check({nm, "_ack"},  {30'd0, if_ack, d_ack}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_rdata", {16'd0, if_rdata, d_rdata}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fetch read of address 4 -> 0x01, ack at +2
        if_addr = 15'h0004; if_req = 1'b1; push(1'b0, 1'b1, 8'h01);
        @(negedge clk);
        check("rd_bus", {17'd0, mem_req_bus}, 32'h0004);
        check("rd_wr",  {31'd0, mem_write_req}, 32'd0);
        @(negedge clk);
        check("rd_lat_ack", {30'd0, if_ack, d_ack}, 32'd2);
        if_req = 1'b0;
        @(negedge clk);
        check_quiet("after_rd");
        check("if_rdata_held", {24'd0, if_rdata}, 32'h01);

        // Data write 0xA5 -> 0x0014, ack at +3
        d_req = 1'b1; d_we = 1'b1; d_addr = 15'h0014; d_wdata = 8'hA5; push(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check("wrA_wr",  {31'd0, mem_write_req}, 32'd1);
        check("wrA_bus", {17'd0, mem_req_bus}, 32'h00A5);
        @(negedge clk);
        check("wrB_wr",  {31'd0, mem_write_req}, 32'd0);
        check("wrB_bus", {17'd0, mem_req_bus}, 32'h0014);
        @(negedge clk);
        check("wr_lat_ack", {30'd0, if_ack, d_ack}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 15'h0014; push(1'b1, 1'b1, 8'hA5);
        wait_ack(1'b1, "rdback_to", n);
        check("rdback_lat", n, 32'd2);
        d_req = 1'b0;

        // Tie after reset: data, fetch, data, fetch
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        push(1'b1, 1'b1, 8'h1E); push(1'b0, 1'b1, 8'h2D);
        push(1'b1, 1'b1, 8'h78); push(1'b0, 1'b1, 8'h0F);
        if_addr = 15'h0011; d_addr = 15'h0022; if_req = 1'b1; d_req = 1'b1;
        fork
            begin
                int m;
                wait_ack(1'b0, "tie_if1", m); if_addr = 15'h0033;
                wait_ack(1'b0, "tie_if2", m); if_req = 1'b0;
            end
            begin
                int m;
                wait_ack(1'b1, "tie_d1", m); d_addr = 15'h0044;
                wait_ack(1'b1, "tie_d2", m); d_req = 1'b0;
            end
        join

        // Held fetch through a data read; if_addr changes during its RD
        @(negedge clk);
        push(1'b1, 1'b1, 8'h1E); push(1'b0, 1'b1, 8'h2D);
        if_addr = 15'h0011; d_addr = 15'h0022; if_req = 1'b1; d_req = 1'b1;
        fork
            begin
                int m;
                wait_ack(1'b1, "held_d", m); d_req = 1'b0;
            end
            begin
                int m;
                m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!(busy && mem_req_bus == 15'h0011) && m < 30);
                check("held_if_rd_bus", {17'd0, mem_req_bus}, 32'h0011);
                if_addr = 15'h0033;
                wait_ack(1'b0, "held_if", m); if_req = 1'b0;
            end
        join

        // Drop request after grant: ack still issued
        @(negedge clk);
        d_addr = 15'h0044; d_req = 1'b1; push(1'b1, 1'b1, 8'h78);
        @(negedge clk);
        d_req = 1'b0;
        check("drop_busy", {31'd0, busy}, 32'd1);
        wait_ack(1'b1, "drop_to", n);

        // Async reset during WR_ADDR: write dropped, no ack
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 15'h0033; d_wdata = 8'h99;
        @(negedge clk);
        check("rst_wrA", {31'd0, mem_write_req}, 32'd1);
        @(negedge clk);
        check("rst_wrB_bus", {17'd0, mem_req_bus}, 32'h0033);
        reset_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        check_quiet("async_rst");
        check("async_rst_rdata", {16'd0, if_rdata, d_rdata}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        push(1'b1, 1'b1, 8'h0F); push(1'b0, 1'b1, 8'h2D);
        if_addr = 15'h0011; d_addr = 15'h0033; if_req = 1'b1; d_req = 1'b1;
        fork
            begin
                int m;
                wait_ack(1'b1, "post_rst_d", m); d_req = 1'b0;
            end
            begin
                int m;
                wait_ack(1'b0, "post_rst_if", m); if_req = 1'b0;
            end
        join

        // Idle: 10 quiet cycles
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_quiet("idle");
        end
        check("if_rdata_final", {24'd0, if_rdata}, 32'h2D);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
